// File: rtl/mandelbrot_fb_writer.sv
// Consumer end of the Mandelbrot result stream: buffers (count, address) beats,
// maps each count to RGB565 and issues one framebuffer write per pixel.
module mandelbrot_fb_writer #(
    parameter int MAXITERS = 256,
    parameter int IW       = $clog2(MAXITERS),
    parameter int AW       = 19,
    parameter int NPIX     = 480000,
    parameter int CNW      = $clog2(NPIX + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           init,
    output logic           done,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [IW-1:0]  in_dat,
    input  logic [AW-1:0]  in_adr,
    output logic           fb_req,
    output logic [AW-1:0]  fb_adr,
    output logic [15:0]    fb_dat,
    input  logic           fb_ack,
    output logic [CNW-1:0] wr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int             FW       = AW + IW;
    localparam logic [CNW-1:0] NPIX_C   = CNW'(NPIX);
    localparam logic [CNW-1:0] LAST_C   = CNW'(NPIX - 1);
    localparam logic [IW-1:0]  INSIDE_C = IW'(MAXITERS - 1);

    // Points inside the set are black; otherwise the top five bits drive red
    // and their complement blue, the low six bits drive green.
    function automatic logic [15:0] colour_map(input logic [IW-1:0] n);
        logic [4:0] hi;
        hi = n[IW-1:IW-5];
        if (n == INSIDE_C) begin
            colour_map = 16'h0000;
        end else begin
            colour_map = {hi, n[5:0], ~hi};
        end
    endfunction

    state_t         state_r, state_s;
    logic           init_d_r;
    logic           init_edge_s, accept_s, retire_s, load_s;
    logic [FW-1:0]  fifo_mem_r [0:1];
    logic           fifo_wp_r, fifo_rp_r;
    logic [1:0]     fifo_cnt_r, fifo_cnt_s;
    logic [FW-1:0]  head_s;
    logic [CNW-1:0] acc_cnt_r, acc_cnt_s;
    logic [CNW-1:0] wr_cnt_r, wr_cnt_s;
    logic           done_r, done_s;
    logic           in_rdy_r, in_rdy_s;
    logic           fb_req_r;
    logic [AW-1:0]  fb_adr_r;
    logic [15:0]    fb_dat_r;

    // Handshake strobes, occupancy, frame control and next ready value
    always_comb begin
        init_edge_s = clk_en & init & ~init_d_r;
        accept_s    = clk_en & in_vld & in_rdy_r;
        retire_s    = clk_en & fb_req_r & fb_ack;
        load_s      = clk_en & (fifo_cnt_r != 2'd0) & (~fb_req_r | fb_ack);
        fifo_cnt_s  = fifo_cnt_r + {1'b0, accept_s} - {1'b0, load_s};
        head_s      = fifo_mem_r[fifo_rp_r];
        state_s     = state_r;
        acc_cnt_s   = acc_cnt_r;
        wr_cnt_s    = wr_cnt_r;
        done_s      = done_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (init_edge_s) begin
                    state_s   = ST_RUN;
                    acc_cnt_s = {CNW{1'b0}};
                    wr_cnt_s  = {CNW{1'b0}};
                    done_s    = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    acc_cnt_s = acc_cnt_r + CNW'(1);
                end else begin
                    acc_cnt_s = acc_cnt_r;
                end
                if (retire_s) begin
                    wr_cnt_s = wr_cnt_r + CNW'(1);
                    if (wr_cnt_r == LAST_C) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    wr_cnt_s = wr_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        in_rdy_s = (state_s == ST_RUN) && (fifo_cnt_s < 2'd2) && (acc_cnt_s < NPIX_C);
    end

    // Frame state, counters and the registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            init_d_r  <= 1'b0;
            acc_cnt_r <= {CNW{1'b0}};
            wr_cnt_r  <= {CNW{1'b0}};
            done_r    <= 1'b0;
            in_rdy_r  <= 1'b0;
        end else if (clk_en) begin
            state_r   <= state_s;
            init_d_r  <= init;
            acc_cnt_r <= acc_cnt_s;
            wr_cnt_r  <= wr_cnt_s;
            done_r    <= done_s;
            in_rdy_r  <= in_rdy_s;
        end
    end

    // Two-entry input buffer; strobes already carry the clock enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem_r[0] <= {FW{1'b0}};
            fifo_mem_r[1] <= {FW{1'b0}};
            fifo_wp_r     <= 1'b0;
            fifo_rp_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            if (accept_s) begin
                fifo_mem_r[fifo_wp_r] <= {in_adr, in_dat};
                fifo_wp_r             <= ~fifo_wp_r;
            end
            if (load_s) begin
                fifo_rp_r <= ~fifo_rp_r;
            end
            fifo_cnt_r <= fifo_cnt_s;
        end
    end

    // Write request register; address and data only change on a load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_req_r <= 1'b0;
            fb_adr_r <= {AW{1'b0}};
            fb_dat_r <= 16'h0000;
        end else if (load_s) begin
            fb_req_r <= 1'b1;
            fb_adr_r <= head_s[FW-1:IW];
            fb_dat_r <= colour_map(head_s[IW-1:0]);
        end else if (retire_s) begin
            fb_req_r <= 1'b0;
        end
    end

    assign in_rdy = in_rdy_r;
    assign fb_req = fb_req_r;
    assign fb_adr = fb_adr_r;
    assign fb_dat = fb_dat_r;
    assign done   = done_r;
    assign wr_cnt = wr_cnt_r;

endmodule

// File: tb/tb_mandelbrot_fb_writer.sv
// Directed bench for mandelbrot_fb_writer with a 4-pixel frame and 8-bit counts.
module tb_mandelbrot_fb_writer;

    localparam int AW  = 19;
    localparam int CNW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           clk_en = 1'b1;
    logic           init = 1'b0;
    logic           done;
    logic           in_vld = 1'b0;
    logic           in_rdy;
    logic [7:0]     in_dat = 8'h00;
    logic [AW-1:0]  in_adr = '0;
    logic           fb_req;
    logic [AW-1:0]  fb_adr;
    logic [15:0]    fb_dat;
    logic           fb_ack = 1'b1;
    logic [CNW-1:0] wr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mandelbrot_fb_writer #(
        .MAXITERS(256), .IW(8), .AW(AW), .NPIX(4), .CNW(CNW)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .init(init), .done(done),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_adr(in_adr),
        .fb_req(fb_req), .fb_adr(fb_adr), .fb_dat(fb_dat), .fb_ack(fb_ack),
        .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %0b want 0", in_rdy); end
        n_tests++; if (fb_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", fb_req); end
        n_tests++; if (fb_adr !== 19'd0) begin n_fail++; $display("FAIL reset_adr got %0h want 0", fb_adr); end
        n_tests++; if (fb_dat !== 16'h0000) begin n_fail++; $display("FAIL reset_dat got %0h want 0", fb_dat); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_tests++; if (wr_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", wr_cnt); end
        step(); step();
        rst = 1'b0;
        step();
        n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL idle_rdy got %0b want 0", in_rdy); end
        init = 1'b1;
        step();
        init = 1'b0;
        n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL init_rdy got %0b want 1", in_rdy); end
    endtask

    // Starts in the first ready cycle of a fresh frame, fb_ack high
    task automatic test_colour();
        logic [7:0]  dat [4];
        logic [15:0] col [4];
        dat = '{8'h00, 8'hA5, 8'hFF, 8'h3F};
        col = '{16'h001F, 16'hA4AB, 16'h0000, 16'h3FF8};
        for (int c = 0; c < 7; c++) begin
            if (c >= 2 && c <= 5) begin
                n_tests++; if (fb_req !== 1'b1) begin n_fail++; $display("FAIL colour_req c%0d got %0b want 1", c, fb_req); end
                n_tests++; if (fb_adr !== 19'(c - 2)) begin n_fail++; $display("FAIL colour_adr c%0d got %0d want %0d", c, fb_adr, c - 2); end
                n_tests++; if (fb_dat !== col[c-2]) begin n_fail++; $display("FAIL colour_dat c%0d got %h want %h", c, fb_dat, col[c-2]); end
                n_tests++; if (wr_cnt !== 3'(c - 2)) begin n_fail++; $display("FAIL colour_cnt c%0d got %0d want %0d", c, wr_cnt, c - 2); end
                n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL colour_early_done c%0d got %0b want 0", c, done); end
            end
            if (c < 4) begin
                n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL colour_rdy c%0d got %0b want 1", c, in_rdy); end
                in_vld = 1'b1; in_dat = dat[c]; in_adr = 19'(c);
            end else begin
                in_vld = 1'b0;
                n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL colour_rdy_off c%0d got %0b want 0", c, in_rdy); end
            end
            if (c < 6) step();
        end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL colour_done got %0b want 1", done); end
        n_tests++; if (wr_cnt !== 3'd4) begin n_fail++; $display("FAIL colour_final_cnt got %0d want 4", wr_cnt); end
        n_tests++; if (fb_req !== 1'b0) begin n_fail++; $display("FAIL colour_final_req got %0b want 0", fb_req); end
    endtask

    // Restart from DONE, stall the write port, then a fifth beat is refused
    task automatic test_back_pressure();
        logic [7:0]  dat [5];
        logic [15:0] col [4];
        int          idx;
        dat = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h55};
        col = '{16'h121D, 16'h241B, 16'h3619, 16'h4017};
        init = 1'b1;
        step();
        init = 1'b0;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done got %0b want 0", done); end
        n_tests++; if (wr_cnt !== 3'd0) begin n_fail++; $display("FAIL restart_cnt got %0d want 0", wr_cnt); end
        for (int c = 0; c < 12; c++) begin
            idx    = (c < 3) ? c : ((c < 8) ? 3 : 4);
            in_vld = 1'b1; in_dat = dat[idx]; in_adr = 19'(10 + idx);
            fb_ack = (c >= 6);
            if (c <= 2 || c == 7) begin
                n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_on c%0d got %0b want 1", c, in_rdy); end
            end else begin
                n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_off c%0d got %0b want 0", c, in_rdy); end
            end
            if (c >= 2 && c <= 5) begin
                n_tests++; if (fb_req !== 1'b1 || fb_adr !== 19'd10 || fb_dat !== col[0]) begin n_fail++; $display("FAIL bp_hold c%0d got req=%0b adr=%0d dat=%h want req=1 adr=10 dat=%h", c, fb_req, fb_adr, fb_dat, col[0]); end
                n_tests++; if (wr_cnt !== 3'd0) begin n_fail++; $display("FAIL bp_hold_cnt c%0d got %0d want 0", c, wr_cnt); end
            end
            if (c >= 6 && c <= 9) begin
                n_tests++; if (fb_req !== 1'b1 || fb_adr !== 19'(4 + c) || fb_dat !== col[c-6]) begin n_fail++; $display("FAIL bp_drain c%0d got req=%0b adr=%0d dat=%h want req=1 adr=%0d dat=%h", c, fb_req, fb_adr, fb_dat, 4 + c, col[c-6]); end
                n_tests++; if (wr_cnt !== 3'(c - 6)) begin n_fail++; $display("FAIL bp_drain_cnt c%0d got %0d want %0d", c, wr_cnt, c - 6); end
            end
            if (c >= 10) begin
                n_tests++; if (done !== 1'b1 || wr_cnt !== 3'd4 || fb_req !== 1'b0) begin n_fail++; $display("FAIL bp_end c%0d got done=%0b cnt=%0d req=%0b want done=1 cnt=4 req=0", c, done, wr_cnt, fb_req); end
            end
            if (c < 11) step();
        end
        in_vld = 1'b0;
        fb_ack = 1'b1;
    endtask

    // init edge while running is ignored; clk_en low freezes a pending write
    task automatic test_frame_control();
        logic [15:0] col [4];
        int          idx;
        col = '{16'h003F, 16'h005F, 16'h007F, 16'h009F};
        init = 1'b1;
        step();
        init = 1'b0;
        for (int c = 0; c < 10; c++) begin
            idx    = (c < 3) ? c : 3;
            in_vld = (c <= 6);
            in_dat = 8'(idx + 1); in_adr = 19'(20 + idx);
            init   = (c == 1);
            clk_en = !(c >= 3 && c <= 5);
            if (c <= 1) begin
                n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL fc_rdy c%0d got %0b want 1", c, in_rdy); end
            end
            if (c == 2) begin
                n_tests++; if (fb_req !== 1'b1 || fb_adr !== 19'd20 || fb_dat !== col[0] || wr_cnt !== 3'd0) begin n_fail++; $display("FAIL fc_first c%0d got req=%0b adr=%0d dat=%h cnt=%0d want 1/20/%h/0", c, fb_req, fb_adr, fb_dat, wr_cnt, col[0]); end
            end
            if (c >= 3 && c <= 6) begin
                n_tests++; if (fb_req !== 1'b1 || fb_adr !== 19'd21 || fb_dat !== col[1]) begin n_fail++; $display("FAIL fc_freeze c%0d got req=%0b adr=%0d dat=%h want 1/21/%h", c, fb_req, fb_adr, fb_dat, col[1]); end
                n_tests++; if (wr_cnt !== 3'd1 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL fc_freeze_cnt c%0d got cnt=%0d rdy=%0b want 1/1", c, wr_cnt, in_rdy); end
            end
            if (c == 7 || c == 8) begin
                n_tests++; if (fb_req !== 1'b1 || fb_adr !== 19'(15 + c) || fb_dat !== col[c-5] || wr_cnt !== 3'(c - 5)) begin n_fail++; $display("FAIL fc_resume c%0d got req=%0b adr=%0d dat=%h cnt=%0d want 1/%0d/%h/%0d", c, fb_req, fb_adr, fb_dat, wr_cnt, 15 + c, col[c-5], c - 5); end
                n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL fc_rdy_off c%0d got %0b want 0", c, in_rdy); end
            end
            if (c == 9) begin
                n_tests++; if (done !== 1'b1 || wr_cnt !== 3'd4 || fb_req !== 1'b0) begin n_fail++; $display("FAIL fc_end got done=%0b cnt=%0d req=%0b want 1/4/0", done, wr_cnt, fb_req); end
            end
            if (c < 9) step();
        end
        in_vld = 1'b0;
        init   = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0]  dat [4];
        logic [15:0] col [4];
        dat = '{8'h00, 8'hFF, 8'hA5, 8'h3F};
        col = '{16'h001F, 16'h0000, 16'hA4AB, 16'h3FF8};
        init = 1'b1;
        step();
        init = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_vld = 1'b1; in_dat = dat[c]; in_adr = 19'(30 + c);
            step();
        end
        in_vld = 1'b0;
        n_tests++; if (wr_cnt !== 3'd2 || fb_req !== 1'b1) begin n_fail++; $display("FAIL rmf_pre got cnt=%0d req=%0b want 2/1", wr_cnt, fb_req); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (fb_req !== 1'b0 || wr_cnt !== 3'd0 || in_rdy !== 1'b0) begin n_fail++; $display("FAIL rmf_async got req=%0b cnt=%0d rdy=%0b want 0/0/0", fb_req, wr_cnt, in_rdy); end
        n_tests++; if (fb_adr !== 19'd0 || fb_dat !== 16'h0000 || done !== 1'b0) begin n_fail++; $display("FAIL rmf_async_data got adr=%0d dat=%h done=%0b want 0/0/0", fb_adr, fb_dat, done); end
        step();
        rst = 1'b0;
        step();
        init = 1'b1;
        step();
        init = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c >= 2 && c <= 5) begin
                n_tests++; if (fb_req !== 1'b1 || fb_adr !== 19'(38 + c) || fb_dat !== col[c-2] || wr_cnt !== 3'(c - 2)) begin n_fail++; $display("FAIL rmf_write c%0d got req=%0b adr=%0d dat=%h cnt=%0d want 1/%0d/%h/%0d", c, fb_req, fb_adr, fb_dat, wr_cnt, 38 + c, col[c-2], c - 2); end
            end
            if (c < 4) begin
                n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rmf_rdy c%0d got %0b want 1", c, in_rdy); end
                in_vld = 1'b1; in_dat = dat[c]; in_adr = 19'(40 + c);
            end else begin
                in_vld = 1'b0;
            end
            if (c < 6) step();
        end
        n_tests++; if (done !== 1'b1 || wr_cnt !== 3'd4 || fb_req !== 1'b0) begin n_fail++; $display("FAIL rmf_end got done=%0b cnt=%0d req=%0b want 1/4/0", done, wr_cnt, fb_req); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_colour();
        test_back_pressure();
        test_frame_control();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
